// File: rtl/lc3_pkg.sv
// Shared constants and storage types for the LC-3 register file.
package lc3_pkg;

  localparam int unsigned LC3_DATA_W = 16;
  localparam int unsigned LC3_NREG   = 8;
  localparam int unsigned LC3_IDX_W  = 3;

  typedef logic [LC3_DATA_W-1:0] lc3_word_t;
  typedef lc3_word_t             lc3_regarray_t [LC3_NREG];

endpackage

// File: rtl/lc3_regfile_if.sv
// Register-file bus: write strobe, one-hot load lines, read selects and status outputs.
interface lc3_regfile_if #(
  parameter int unsigned DATA_W = 16
);

  logic              LD_REG;
  logic              R0, R1, R2, R3, R4, R5, R6, R7;
  logic [DATA_W-1:0] BUS;
  logic [2:0]        SR1;
  logic [2:0]        SR2;
  logic [DATA_W-1:0] SR1_OUT;
  logic [DATA_W-1:0] SR2_OUT;
  logic [2:0]        LAST_DR;
  logic              LAST_VALID;
  logic              ONEHOT_ERR;
  logic [7:0]        WR_COUNT;

  modport master (
    output LD_REG, R0, R1, R2, R3, R4, R5, R6, R7, BUS, SR1, SR2,
    input  SR1_OUT, SR2_OUT, LAST_DR, LAST_VALID, ONEHOT_ERR, WR_COUNT
  );

  modport slave (
    input  LD_REG, R0, R1, R2, R3, R4, R5, R6, R7, BUS, SR1, SR2,
    output SR1_OUT, SR2_OUT, LAST_DR, LAST_VALID, ONEHOT_ERR, WR_COUNT
  );

endinterface

// File: rtl/onehot_encoder8.sv
// Combinational one-hot to binary encoder; flags whether exactly one line is set.
module onehot_encoder8 (
  input  logic [7:0] i_lines,
  output logic [2:0] o_index,
  output logic       o_exactly_one
);

  logic [3:0] w_count;

  always_comb begin
    o_index = '0;
    w_count = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_lines[i]) begin
        o_index = 3'(i);
        w_count = w_count + 4'd1;
      end
    end
    o_exactly_one = (w_count == 4'd1);
  end

endmodule

// File: rtl/lc3_regfile.sv
// LC-3 eight-entry register file with one-hot destination load, two async read ports
// and write-tracking status (last destination, accepted-write count, sticky load error).
module lc3_regfile
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = LC3_DATA_W,
  parameter int unsigned NREG   = LC3_NREG
) (
  input  logic                 Clk,
  input  logic                 Reset,
  lc3_regfile_if.slave         rf_if
);

  lc3_regarray_t r_regs;
  logic [2:0]    r_last_dr;
  logic          r_last_valid;
  logic          r_onehot_err;
  logic [7:0]    r_wr_count;

  logic [7:0]    w_lines;
  logic [2:0]    w_index;
  logic          w_exactly_one;
  logic          w_accept;
  logic          w_error;

  assign w_lines = {rf_if.R7, rf_if.R6, rf_if.R5, rf_if.R4,
                    rf_if.R3, rf_if.R2, rf_if.R1, rf_if.R0};

  onehot_encoder8 u_enc (
    .i_lines       (w_lines),
    .o_index       (w_index),
    .o_exactly_one (w_exactly_one)
  );

  assign w_accept = rf_if.LD_REG & w_exactly_one;
  assign w_error  = rf_if.LD_REG & ~w_exactly_one;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_last_dr    <= '0;
      r_last_valid <= 1'b0;
      r_onehot_err <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      if (w_accept) begin
        r_regs[w_index] <= rf_if.BUS;
        r_last_dr       <= w_index;
        r_last_valid    <= 1'b1;
        r_wr_count      <= r_wr_count + 8'd1;
      end
      // Sticky: only Reset clears it.
      if (w_error) begin
        r_onehot_err <= 1'b1;
      end
    end
  end

  // No bypass: reads always reflect stored contents.
  assign rf_if.SR1_OUT    = r_regs[rf_if.SR1];
  assign rf_if.SR2_OUT    = r_regs[rf_if.SR2];
  assign rf_if.LAST_DR    = r_last_dr;
  assign rf_if.LAST_VALID = r_last_valid;
  assign rf_if.ONEHOT_ERR = r_onehot_err;
  assign rf_if.WR_COUNT   = r_wr_count;

endmodule

// File: tb/tb_lc3_regfile.sv
// Directed self-checking bench for lc3_regfile.
module tb_lc3_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lc3_regfile_if #(.DATA_W(16)) rf ();

  lc3_regfile #(.DATA_W(16), .NREG(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .rf_if (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lines(input logic [7:0] v);
    {rf.R7, rf.R6, rf.R5, rf.R4, rf.R3, rf.R2, rf.R1, rf.R0} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] d);
    rf.LD_REG = 1'b1;
    set_lines(8'd1 << idx);
    rf.BUS = d;
    step();
    rf.LD_REG = 1'b0;
    set_lines(8'h00);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [15:0] exp, input string tag);
    rf.SR1 = idx;
    rf.SR2 = idx;
    #1;
    chk({tag, "_sr1"}, rf.SR1_OUT, exp);
    chk({tag, "_sr2"}, rf.SR2_OUT, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rf.LD_REG = 1'b0;
    set_lines(8'h00);
    rf.BUS = 16'h0000;
    rf.SR1 = 3'd0;
    rf.SR2 = 3'd0;

    // Reset state
    #1;
    chk("rst_sr1", rf.SR1_OUT, 16'h0000);
    chk("rst_valid", 16'(rf.LAST_VALID), 16'h0000);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_cnt", 16'(rf.WR_COUNT), 16'h0000);
    chk("post_rst_err", 16'(rf.ONEHOT_ERR), 16'h0000);
    chk("post_rst_dr", 16'(rf.LAST_DR), 16'h0000);

    // Basic write/read
    wr(3'd3, 16'hBEEF);
    rf.SR1 = 3'd3;
    rf.SR2 = 3'd0;
    #1;
    chk("basic_sr1", rf.SR1_OUT, 16'hBEEF);
    chk("basic_sr2", rf.SR2_OUT, 16'h0000);
    chk("basic_dr", 16'(rf.LAST_DR), 16'h0003);
    chk("basic_valid", 16'(rf.LAST_VALID), 16'h0001);
    chk("basic_cnt", 16'(rf.WR_COUNT), 16'h0001);

    // Lines ignored while LD_REG=0
    rf.LD_REG = 1'b0;
    set_lines(8'hFF);
    rf.BUS = 16'hFFFF;
    for (int i = 0; i < 5; i++) step();
    set_lines(8'h00);
    rd(3'd3, 16'hBEEF, "ign_r3");
    rd(3'd0, 16'h0000, "ign_r0");
    chk("ign_err", 16'(rf.ONEHOT_ERR), 16'h0000);
    chk("ign_cnt", 16'(rf.WR_COUNT), 16'h0001);

    // Malformed load (two lines)
    wr(3'd1, 16'h1111);
    wr(3'd5, 16'h5555);
    rf.LD_REG = 1'b1;
    set_lines(8'b0010_0010);
    rf.BUS = 16'h1234;
    step();
    rf.LD_REG = 1'b0;
    set_lines(8'h00);
    rd(3'd1, 16'h1111, "bad_r1");
    rd(3'd5, 16'h5555, "bad_r5");
    chk("bad_err", 16'(rf.ONEHOT_ERR), 16'h0001);
    chk("bad_cnt", 16'(rf.WR_COUNT), 16'h0003);
    chk("bad_dr", 16'(rf.LAST_DR), 16'h0005);
    wr(3'd2, 16'h2222);
    rd(3'd2, 16'h2222, "fix_r2");
    chk("fix_err_sticky", 16'(rf.ONEHOT_ERR), 16'h0001);
    chk("fix_cnt", 16'(rf.WR_COUNT), 16'h0004);
    chk("fix_dr", 16'(rf.LAST_DR), 16'h0002);

    // No bypass
    wr(3'd7, 16'hABCD);
    rf.SR1 = 3'd7;
    rf.SR2 = 3'd7;
    rf.LD_REG = 1'b1;
    set_lines(8'h80);
    rf.BUS = 16'h00FF;
    #1;
    chk("nobyp_before", rf.SR1_OUT, 16'hABCD);
    step();
    rf.LD_REG = 1'b0;
    set_lines(8'h00);
    chk("nobyp_after1", rf.SR1_OUT, 16'h00FF);
    chk("nobyp_after2", rf.SR2_OUT, 16'h00FF);
    chk("nobyp_cnt", 16'(rf.WR_COUNT), 16'h0006);

    // Write everything, then async reset between edges with a write pending
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
    rd(3'd4, 16'h1004, "all_r4");
    chk("all_cnt", 16'(rf.WR_COUNT), 16'h000E);
    rf.SR1 = 3'd7;
    rf.SR2 = 3'd4;
    rf.LD_REG = 1'b1;
    set_lines(8'h10);
    rf.BUS = 16'h9999;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sr1", rf.SR1_OUT, 16'h0000);
    chk("arst_sr2", rf.SR2_OUT, 16'h0000);
    chk("arst_cnt", 16'(rf.WR_COUNT), 16'h0000);
    chk("arst_valid", 16'(rf.LAST_VALID), 16'h0000);
    chk("arst_dr", 16'(rf.LAST_DR), 16'h0000);
    step();
    rf.LD_REG = 1'b0;
    set_lines(8'h00);
    #2;
    rst = 1'b0;
    #1;
    rd(3'd4, 16'h0000, "arst_discard_r4");
    chk("arst_discard_cnt", 16'(rf.WR_COUNT), 16'h0000);

    // No lines with LD_REG=1 is also an error
    rf.LD_REG = 1'b1;
    set_lines(8'h00);
    rf.BUS = 16'h7777;
    step();
    rf.LD_REG = 1'b0;
    chk("zero_err", 16'(rf.ONEHOT_ERR), 16'h0001);
    chk("zero_cnt", 16'(rf.WR_COUNT), 16'h0000);
    chk("zero_valid", 16'(rf.LAST_VALID), 16'h0000);
    rd(3'd0, 16'h0000, "zero_r0");
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("zero_err_clr", 16'(rf.ONEHOT_ERR), 16'h0000);

    // Counter wrap: 256 writes cycling R0..R7
    for (int i = 0; i < 255; i++) wr(3'(i % 8), 16'(i));
    chk("wrap_255", 16'(rf.WR_COUNT), 16'h00FF);
    wr(3'd7, 16'd255);
    chk("wrap_cnt", 16'(rf.WR_COUNT), 16'h0000);
    chk("wrap_dr", 16'(rf.LAST_DR), 16'h0007);
    chk("wrap_valid", 16'(rf.LAST_VALID), 16'h0001);
    rd(3'd7, 16'd255, "wrap_r7");
    rd(3'd0, 16'd248, "wrap_r0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
